pe_fxp_db: RTL and testbench
============================

Name: pe_fxp_db

Overview:
Parametrised successor processing element for the weight-stationary systolic array.
- Fixed-point MAC with configurable width and fraction bits, round-to-nearest and saturation.
- Double-buffered weights, sequenced by an explicit armed/empty state machine. The active weight is updated only by registers, with a same-cycle bypass.
- pe_enabled holds state rather than clearing it.
- Tiles into rows and columns exactly like the current PE: psum and weights flow south; inputs, valid and switch flow east.

Parameters:
- DATA_WIDTH, 16, bit width of inputs, weights and psums (signed two's complement), 4..32.
- FRAC_BITS, 8, fraction bits of the fixed-point format, 0 < FRAC_BITS < DATA_WIDTH.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pe_enabled  in  1  1 = operate; 0 = freeze state and drive idle outputs.
- pe_psum_in  in  DATA_WIDTH  partial sum from north.
- pe_weight_in  in  DATA_WIDTH  weight from north chain.
- pe_accept_w_in  in  1  weight on pe_weight_in is valid.
- pe_input_in  in  DATA_WIDTH  activation from west.
- pe_valid_in  in  1  activation valid.
- pe_switch_in  in  1  promote inactive weight to active.
- pe_psum_out  out  DATA_WIDTH  MAC result to south.
- pe_weight_out  out  DATA_WIDTH  forwarded weight to south.
- pe_accept_w_out  out  1  forwarded accept to south.
- pe_input_out  out  DATA_WIDTH  forwarded activation to east.
- pe_valid_out  out  1  forwarded valid to east.
- pe_switch_out  out  1  forwarded switch to east.
- pe_w_armed  out  1  inactive buffer holds an unconsumed weight.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs are 0.
  - Active and inactive weights are 0.
  - FSM is W_EMPTY.
- Latency: every output is registered; 1 cycle from the inputs.

- Weight FSM:
  - States: W_EMPTY, W_ARMED. pe_w_armed = (state==W_ARMED).
  - accept only: inactive<=pe_weight_in; move to W_ARMED.
  - switch in W_ARMED: active<=inactive; move to W_EMPTY.
  - switch in W_EMPTY: active unchanged; stay W_EMPTY (weight reuse, not an error).
  - accept and switch in the same cycle:
    - If W_ARMED, the switch consumes the old inactive; inactive<=new weight; state ends W_ARMED.
    - If W_EMPTY, active is unchanged; inactive<=new weight; state ends W_ARMED.
- Effective weight w_eff for the MAC:
  - inactive when (pe_switch_in and W_ARMED); otherwise active.
  - Activations presented with the switch therefore use the new weight in the same cycle.
- Weight chain outputs:
  - pe_weight_out <= accept ? pe_weight_in : 0.
  - pe_accept_w_out <= pe_accept_w_in.

- Arithmetic:
  - p = pe_input_in * w_eff, full 2*DATA_WIDTH signed.
  - Round half-up: r = (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS.
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
  - s = sat(r) + pe_psum_in, computed at DW+1 bits, then saturated to DW.
- Valid path:
  - pe_valid_in=1: pe_psum_out<=s; pe_input_out<=pe_input_in; pe_valid_out<=1.
  - pe_valid_in=0: pe_psum_out<=0; pe_input_out holds; pe_valid_out<=0.
- pe_switch_out <= pe_switch_in, independent of valid.

- pe_enabled=0:
  - Weights, FSM and pe_input_out hold.
  - pe_psum_out, pe_weight_out, pe_accept_w_out, pe_valid_out and pe_switch_out are registered to 0.
  - accept and switch are ignored.
- Reset mid-operation clears everything immediately. Any pending armed weight is discarded.

Optional Feature:
- Macro: PE_FXP_OVF_FLAG_EN.
- Defined:
  - Adds output pe_ovf (1 bit). It is sticky: set on any cycle where pe_valid_in=1, pe_enabled=1, and either saturation step clipped.
  - Cleared only by rst_n.
  - Reset value 0.
- Undefined: the port and its logic are absent; arithmetic is unchanged.

Decomposition:
- Shared package pe_pkg:
  - typedef enum logic {W_EMPTY, W_ARMED} w_state_t.
  - Function sat_trunc (generic width clip).
  - Default width and fraction constants reused by the array top.
- One sub-module, fxp_mac_sat: combinational multiply, round, saturate, add.
  - Parameters DATA_WIDTH and FRAC_BITS.
  - Outputs sum and ovf.
  - Instanced once by pe_fxp_db.

Test Plan:
- Q8.8 basic MAC: load 0x0200, then switch with valid.
  - Stimulus: input 0x0180, psum 0x0100.
  - Next cycle: psum_out=0x0400, valid_out=1, input_out=0x0180.
- Same-cycle bypass:
  - Active 0x0100, inactive 0x0300 armed.
  - switch+valid with input 0x0100, psum 0 -> psum_out=0x0300, pe_w_armed drops to 0.
  - Following valid with input 0x0100 -> 0x0300 again.
- Saturation:
  - Weight 0x0200, input 0x7F00, psum 0 -> 0x7FFF.
  - Input 0x8000 -> 0x8000.
  - With PE_FXP_OVF_FLAG_EN: pe_ovf=1 and stays 1.
- Rounding:
  - Weight 0x0080, input 0x0001 -> 0x0001.
  - Input 0xFFFF -> 0x0000 (half-up).
- Accept+switch collision:
  - Armed inactive 0x0500; accept 0x0700 and switch in the same cycle.
  - Result: active=0x0500, inactive=0x0700, pe_w_armed=1.
  - Weight chain: weight_out=0x0700, accept_w_out=1.
- Enable/reset:
  - Drop pe_enabled for 3 cycles mid-stream: outputs 0, weights retained; resume gives identical results.
  - Assert rst_n=0 asynchronously between clock edges: all outputs 0 before the next edge; pe_w_armed=0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types, default widths and the saturation helper for the fixed-point PE family.
package pe_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FRAC_BITS  = 8;

  typedef enum logic {W_EMPTY, W_ARMED} w_state_t;

  // Clip a wide signed value into the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fxp_mac_sat.sv
// Combinational fixed-point multiply, round-half-up, saturate and saturating accumulate.
module fxp_mac_sat
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] w,
  input  logic signed [DATA_WIDTH-1:0] psum,
  output logic signed [DATA_WIDTH-1:0] sum,
  output logic                         ovf
);

  logic signed [63:0] prod;
  logic signed [63:0] rnd;
  logic signed [63:0] rnd_sat;
  logic signed [63:0] acc;
  logic signed [63:0] acc_sat;

  // 64-bit working width holds the full product for any DATA_WIDTH up to 32.
  always_comb begin
    prod    = 64'(a) * 64'(w);
    rnd     = (prod + (64'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
    rnd_sat = sat_trunc(rnd, DATA_WIDTH);
    acc     = rnd_sat + 64'(psum);
    acc_sat = sat_trunc(acc, DATA_WIDTH);
    sum     = DATA_WIDTH'(acc_sat);
    ovf     = (rnd_sat != rnd) || (acc_sat != acc);
  end

endmodule

// File: rtl/pe_fxp_db.sv
// Weight-stationary fixed-point PE with double-buffered weights and same-cycle switch bypass.
// Optional sticky overflow flag output pe_ovf when PE_FXP_OVF_FLAG_EN is defined.
module pe_fxp_db
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pe_enabled,
  input  logic [DATA_WIDTH-1:0] pe_psum_in,
  input  logic [DATA_WIDTH-1:0] pe_weight_in,
  input  logic                  pe_accept_w_in,
  input  logic [DATA_WIDTH-1:0] pe_input_in,
  input  logic                  pe_valid_in,
  input  logic                  pe_switch_in,
  output logic [DATA_WIDTH-1:0] pe_psum_out,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  output logic                  pe_accept_w_out,
  output logic [DATA_WIDTH-1:0] pe_input_out,
  output logic                  pe_valid_out,
  output logic                  pe_switch_out,
  output logic                  pe_w_armed
`ifdef PE_FXP_OVF_FLAG_EN
  ,
  output logic                  pe_ovf
`endif
);

  w_state_t              state;
  w_state_t              state_d;
  logic [DATA_WIDTH-1:0] w_active;
  logic [DATA_WIDTH-1:0] w_active_d;
  logic [DATA_WIDTH-1:0] w_inactive;
  logic [DATA_WIDTH-1:0] w_inactive_d;
  logic                  promote_c;
  logic [DATA_WIDTH-1:0] w_eff_c;
  logic [DATA_WIDTH-1:0] mac_sum;
  logic                  mac_ovf;

  assign promote_c = pe_switch_in && (state == W_ARMED);
  assign w_eff_c   = promote_c ? w_inactive : w_active;

  fxp_mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .a    (pe_input_in),
    .w    (w_eff_c),
    .psum (pe_psum_in),
    .sum  (mac_sum),
    .ovf  (mac_ovf)
  );

  // Weight buffer sequencing; a same-cycle accept always re-arms with the new weight.
  always_comb begin
    state_d      = state;
    w_active_d   = w_active;
    w_inactive_d = w_inactive;
    if (pe_enabled) begin
      if (promote_c) begin
        w_active_d = w_inactive;
      end
      if (pe_accept_w_in) begin
        w_inactive_d = pe_weight_in;
        state_d      = W_ARMED;
      end else if (pe_switch_in) begin
        state_d = W_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= W_EMPTY;
      w_active   <= '0;
      w_inactive <= '0;
    end else begin
      state      <= state_d;
      w_active   <= w_active_d;
      w_inactive <= w_inactive_d;
    end
  end

  assign pe_w_armed = (state == W_ARMED);

  // Dataflow outputs; a disabled PE emits idles but keeps the last forwarded activation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_psum_out     <= '0;
      pe_weight_out   <= '0;
      pe_accept_w_out <= 1'b0;
      pe_input_out    <= '0;
      pe_valid_out    <= 1'b0;
      pe_switch_out   <= 1'b0;
    end else if (pe_enabled) begin
      pe_psum_out     <= pe_valid_in ? mac_sum : '0;
      pe_weight_out   <= pe_accept_w_in ? pe_weight_in : '0;
      pe_accept_w_out <= pe_accept_w_in;
      if (pe_valid_in) begin
        pe_input_out <= pe_input_in;
      end
      pe_valid_out    <= pe_valid_in;
      pe_switch_out   <= pe_switch_in;
    end else begin
      pe_psum_out     <= '0;
      pe_weight_out   <= '0;
      pe_accept_w_out <= 1'b0;
      pe_valid_out    <= 1'b0;
      pe_switch_out   <= 1'b0;
    end
  end

`ifdef PE_FXP_OVF_FLAG_EN
  // Sticky clip indicator, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_ovf <= 1'b0;
    end else if (pe_enabled && pe_valid_in && mac_ovf) begin
      pe_ovf <= 1'b1;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = mac_ovf;
`endif

endmodule

// File: tb/tb_pe_fxp_db.sv
// Self-checking bench for pe_fxp_db: directed Q8.8 vectors plus randomized traffic vs a behavioural model.
module tb_pe_fxp_db;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] psum_in;
  logic [15:0] weight_in;
  logic        accept;
  logic [15:0] input_in;
  logic        valid;
  logic        sw;
  logic [15:0] psum_out;
  logic [15:0] weight_out;
  logic        accept_out;
  logic [15:0] input_out;
  logic        valid_out;
  logic        switch_out;
  logic        armed;
`ifdef PE_FXP_OVF_FLAG_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  pe_fxp_db #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pe_enabled      (en),
    .pe_psum_in      (psum_in),
    .pe_weight_in    (weight_in),
    .pe_accept_w_in  (accept),
    .pe_input_in     (input_in),
    .pe_valid_in     (valid),
    .pe_switch_in    (sw),
    .pe_psum_out     (psum_out),
    .pe_weight_out   (weight_out),
    .pe_accept_w_out (accept_out),
    .pe_input_out    (input_out),
    .pe_valid_out    (valid_out),
    .pe_switch_out   (switch_out),
    .pe_w_armed      (armed)
`ifdef PE_FXP_OVF_FLAG_EN
    ,
    .pe_ovf          (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Q8.8 MAC from first principles: exact product, half-up rounding, two clamps.
  function automatic logic [15:0] q88_mac(input logic [15:0] a, input logic [15:0] w,
                                          input logic [15:0] ps, output bit clipped);
    longint p, r, s;
    clipped = 1'b0;
    p = longint'($signed(a)) * longint'($signed(w));
    r = (p + 128) >>> 8;
    if (r > 32767) begin r = 32767; clipped = 1'b1; end
    if (r < -32768) begin r = -32768; clipped = 1'b1; end
    s = r + longint'($signed(ps));
    if (s > 32767) begin s = 32767; clipped = 1'b1; end
    if (s < -32768) begin s = -32768; clipped = 1'b1; end
    return 16'(s);
  endfunction

  // Behavioural model: current weight, pending weight and whether one is pending.
  logic [15:0] m_cur, m_pend;
  bit          m_has_pend;
  logic [15:0] e_psum, e_weight, e_input;
  bit          e_accept, e_valid, e_switch, e_ovf;

  always @(posedge clk or negedge rst_n) begin
    bit          clip;
    logic [15:0] w_use;
    logic [15:0] res;
    if (!rst_n) begin
      m_cur <= '0; m_pend <= '0; m_has_pend <= 1'b0;
      e_psum <= '0; e_weight <= '0; e_input <= '0;
      e_accept <= 1'b0; e_valid <= 1'b0; e_switch <= 1'b0; e_ovf <= 1'b0;
    end else if (en) begin
      w_use = (sw && m_has_pend) ? m_pend : m_cur;
      res   = q88_mac(input_in, w_use, psum_in, clip);
      e_psum   <= valid ? res : 16'h0000;
      if (valid) e_input <= input_in;
      if (valid && clip) e_ovf <= 1'b1;
      e_valid  <= valid;
      e_switch <= sw;
      e_accept <= accept;
      e_weight <= accept ? weight_in : 16'h0000;
      if (sw && m_has_pend) m_cur <= m_pend;
      if (accept) begin
        m_pend <= weight_in;
        m_has_pend <= 1'b1;
      end else if (sw) begin
        m_has_pend <= 1'b0;
      end
    end else begin
      e_psum <= '0; e_weight <= '0; e_accept <= 1'b0; e_valid <= 1'b0; e_switch <= 1'b0;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_psum", 32'(psum_out), 32'(e_psum));
      chk("m_weight", 32'(weight_out), 32'(e_weight));
      chk("m_accept", 32'(accept_out), 32'(e_accept));
      chk("m_input", 32'(input_out), 32'(e_input));
      chk("m_valid", 32'(valid_out), 32'(e_valid));
      chk("m_switch", 32'(switch_out), 32'(e_switch));
      chk("m_armed", 32'(armed), 32'(m_has_pend));
`ifdef PE_FXP_OVF_FLAG_EN
      chk("m_ovf", 32'(ovf), 32'(e_ovf));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    accept = 1'b0; sw = 1'b0; valid = 1'b0;
    weight_in = '0; input_in = '0; psum_in = '0;
  endtask

  task automatic load(input logic [15:0] w);
    idle(); accept = 1'b1; weight_in = w; cyc();
    idle(); sw = 1'b1; cyc();
    idle();
  endtask

  task automatic mac(input logic [15:0] a, input logic [15:0] ps, input bit s);
    idle(); valid = 1'b1; input_in = a; psum_in = ps; sw = s; cyc();
    idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psum"}, 32'(psum_out), 32'h0);
    chk({tag, "_weight"}, 32'(weight_out), 32'h0);
    chk({tag, "_accept"}, 32'(accept_out), 32'h0);
    chk({tag, "_valid"}, 32'(valid_out), 32'h0);
    chk({tag, "_switch"}, 32'(switch_out), 32'h0);
    chk({tag, "_armed"}, 32'(armed), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; idle();
    cyc(); cyc();
    chk_all_zero("reset");
    chk("reset_input", 32'(input_out), 32'h0);
    check_en = 1'b1;
    rst_n = 1'b1; en = 1'b1;
    cyc();

    // Basic MAC: load 0x0200, then switch with valid.
    idle(); accept = 1'b1; weight_in = 16'h0200; cyc();
    chk("load_wout", 32'(weight_out), 32'h0200);
    chk("load_armed", 32'(armed), 32'h1);
    mac(16'h0180, 16'h0100, 1'b1);
    chk("basic_psum", 32'(psum_out), 32'h0400);
    chk("basic_valid", 32'(valid_out), 32'h1);
    chk("basic_input", 32'(input_out), 32'h0180);
    chk("basic_armed", 32'(armed), 32'h0);

    // Same-cycle bypass.
    load(16'h0100);
    idle(); accept = 1'b1; weight_in = 16'h0300; cyc(); idle();
    mac(16'h0100, 16'h0000, 1'b1);
    chk("bypass_psum", 32'(psum_out), 32'h0300);
    chk("bypass_armed", 32'(armed), 32'h0);
    mac(16'h0100, 16'h0000, 1'b0);
    chk("bypass_next", 32'(psum_out), 32'h0300);

    // Saturation.
    load(16'h0200);
    mac(16'h7F00, 16'h0000, 1'b0);
    chk("sat_pos", 32'(psum_out), 32'h7FFF);
    mac(16'h8000, 16'h0000, 1'b0);
    chk("sat_neg", 32'(psum_out), 32'h8000);
    mac(16'h0001, 16'h0000, 1'b0);
`ifdef PE_FXP_OVF_FLAG_EN
    chk("ovf_sticky", 32'(ovf), 32'h1);
`endif

    // Rounding.
    load(16'h0080);
    mac(16'h0001, 16'h0000, 1'b0);
    chk("round_up", 32'(psum_out), 32'h0001);
    mac(16'hFFFF, 16'h0000, 1'b0);
    chk("round_half", 32'(psum_out), 32'h0000);

    // Accept+switch collision.
    idle(); accept = 1'b1; weight_in = 16'h0500; cyc();
    idle(); accept = 1'b1; weight_in = 16'h0700; sw = 1'b1; cyc(); idle();
    chk("coll_wout", 32'(weight_out), 32'h0700);
    chk("coll_acc", 32'(accept_out), 32'h1);
    chk("coll_armed", 32'(armed), 32'h1);
    mac(16'h0100, 16'h0000, 1'b0);
    chk("coll_active", 32'(psum_out), 32'h0500);
    mac(16'h0100, 16'h0000, 1'b1);
    chk("coll_inactive", 32'(psum_out), 32'h0700);

    // Enable drop mid-stream: outputs idle, state held.
    load(16'h0200);
    mac(16'h0100, 16'h0000, 1'b0);
    chk("en_before", 32'(psum_out), 32'h0200);
    idle(); accept = 1'b1; weight_in = 16'h0600; cyc(); idle();
    for (int i = 0; i < 3; i++) begin
      en = 1'b0;
      accept = 1'($urandom); sw = 1'($urandom); valid = 1'b1;
      weight_in = 16'($urandom); input_in = 16'($urandom); psum_in = 16'($urandom);
      cyc();
      chk("dis_psum", 32'(psum_out), 32'h0);
      chk("dis_valid", 32'(valid_out), 32'h0);
      chk("dis_armed", 32'(armed), 32'h1);
      chk("dis_input", 32'(input_out), 32'h0100);
    end
    en = 1'b1;
    mac(16'h0100, 16'h0000, 1'b0);
    chk("en_after", 32'(psum_out), 32'h0200);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      accept    = ($urandom_range(0, 3) == 0);
      sw        = ($urandom_range(0, 4) == 0);
      valid     = ($urandom_range(0, 3) != 0);
      weight_in = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($signed(12'($urandom)));
      input_in  = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($signed(12'($urandom)));
      psum_in   = 16'($urandom);
      cyc();
    end

    // Asynchronous reset between edges with a pending weight.
    en = 1'b1; idle(); accept = 1'b1; weight_in = 16'h1234; valid = 1'b1;
    input_in = 16'h0100; cyc(); idle();
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("areset");
    chk("areset_input", 32'(input_out), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
